ring_sequencer: RTL and testbench

//  Timing-ring controller that sequences a bank of set/reset triggers.

---
 rtl/ring_sequencer_pkg.sv | 32 +++
 rtl/pulse_edge.sv | 31 +++
 rtl/ring_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_ring_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ring_sequencer_pkg
// Shared definitions for the timing-ring sequencer:
//   - FSM state encoding (RS_IDLE / RS_RUN / RS_HOLD)
//   - dwell counter width RS_CNT_W
//   - legal ranges for the POSITIONS and DWELL parameters and their checks
// No ports; imported by ring_sequencer.
// ---------------------------------------------------------------------------
package ring_sequencer_pkg;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_RUN  = 2'd1,
    RS_HOLD = 2'd2
  } rs_state_e;

  localparam int RS_CNT_W = 8;

  localparam int RS_POS_MIN   = 2;
  localparam int RS_POS_MAX   = 32;
  localparam int RS_DWELL_MIN = 1;
  localparam int RS_DWELL_MAX = 255;

  function automatic bit rs_pos_legal(input int positions);
    return (positions >= RS_POS_MIN) && (positions <= RS_POS_MAX);
  endfunction

  function automatic bit rs_dwell_legal(input int dwell);
    return (dwell >= RS_DWELL_MIN) && (dwell <= RS_DWELL_MAX);
  endfunction

endpackage

// File: rtl/pulse_edge.sv
// ---------------------------------------------------------------------------
// pulse_edge
// Registered rising-edge detector. The output is a one-clock pulse in the
// clock after the input is first sampled high; the history register updates
// every clock regardless of what the consumer is doing.
// Ports:
//   clk    in  1  clock, posedge
//   rst    in  1  asynchronous, active-high reset
//   din    in  1  level input
//   pulse  out 1  registered rising-edge pulse
// ---------------------------------------------------------------------------
module pulse_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      last  <= din;
      pulse <= din & ~last;
    end
  end

endmodule

// File: rtl/ring_sequencer.sv
// ---------------------------------------------------------------------------
// ring_sequencer
// Timing-ring controller: steps a one-hot ring through POSITIONS positions,
// holding each for DWELL clocks, and emits single-clock set/reset pulses for
// a bank of set/reset triggers. Start/stop/hold come from channel command
// logic. All outputs are registered.
//
// Optional feature: define RING_SINGLE_STEP_EN to add i_step_mode/i_step.
// With i_step_mode high, each rising edge of i_step replaces dwell expiry.
//
// Parameters:
//   POSITIONS  ring length (2..32)
//   DWELL      clocks per position (1..255)
// Ports:
//   i_clk          in   1          system clock
//   i_reset        in   1          asynchronous, active-high reset
//   i_start        in   1          rising edge starts one revolution
//   i_stop         in   1          level; aborts the revolution
//   i_hold         in   1          level; freezes the ring in place
//   i_step_mode    in   1          (RING_SINGLE_STEP_EN) advance by i_step
//   i_step         in   1          (RING_SINGLE_STEP_EN) step request edge
//   o_pos          out  POSITIONS  one-hot position, 0 when idle
//   o_set_pulse    out  POSITIONS  pulse on entry to a position
//   o_reset_pulse  out  POSITIONS  pulse on exit from a position
//   o_busy         out  1          high in RUN or HOLD
//   o_done         out  1          revolution completed normally
//   o_abort        out  1          revolution ended by i_stop
// ---------------------------------------------------------------------------
module ring_sequencer
  import ring_sequencer_pkg::*;
#(
  parameter int POSITIONS = 8,
  parameter int DWELL     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_hold,
`ifdef RING_SINGLE_STEP_EN
  input  logic                 i_step_mode,
  input  logic                 i_step,
`endif
  output logic [POSITIONS-1:0] o_pos,
  output logic [POSITIONS-1:0] o_set_pulse,
  output logic [POSITIONS-1:0] o_reset_pulse,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_abort
);

  if (!rs_pos_legal(POSITIONS)) begin : g_bad_positions
    $error("ring_sequencer: POSITIONS out of range 2..32");
  end
  if (!rs_dwell_legal(DWELL)) begin : g_bad_dwell
    $error("ring_sequencer: DWELL out of range 1..255");
  end

  localparam logic [RS_CNT_W-1:0]  DWELL_LAST = RS_CNT_W'(DWELL - 1);
  localparam logic [POSITIONS-1:0] POS_FIRST  = {{(POSITIONS-1){1'b0}}, 1'b1};

  rs_state_e              state, state_next;
  logic [POSITIONS-1:0]   pos, pos_next;
  logic [POSITIONS-1:0]   set_pulse, set_next;
  logic [POSITIONS-1:0]   reset_pulse, reset_next;
  logic [RS_CNT_W-1:0]    cnt, cnt_next;
  logic                   busy, busy_next;
  logic                   done, done_next;
  logic                   abort, abort_next;
  logic                   start_edge;
  logic                   expire;
  logic                   mode_change;

  pulse_edge u_start_edge (
    .clk   (i_clk),
    .rst   (i_reset),
    .din   (i_start),
    .pulse (start_edge)
  );

`ifdef RING_SINGLE_STEP_EN
  logic step_edge;
  logic last_mode;

  pulse_edge u_step_edge (
    .clk   (i_clk),
    .rst   (i_reset),
    .din   (i_step),
    .pulse (step_edge)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) last_mode <= 1'b0;
    else         last_mode <= i_step_mode;
  end

  // A mode switch restarts the position's dwell rather than carrying a
  // partial count across modes.
  assign mode_change = i_step_mode ^ last_mode;
  assign expire      = i_step_mode ? step_edge : (cnt == DWELL_LAST);
`else
  assign mode_change = 1'b0;
  assign expire      = (cnt == DWELL_LAST);
`endif

  always_comb begin
    state_next = state;
    pos_next   = pos;
    cnt_next   = cnt;
    set_next   = '0;
    reset_next = '0;
    done_next  = 1'b0;
    abort_next = 1'b0;

    case (state)
      RS_IDLE: begin
        if (start_edge && !i_stop) begin
          state_next = RS_RUN;
          pos_next   = POS_FIRST;
          set_next   = POS_FIRST;
          cnt_next   = '0;
        end
      end
      RS_RUN, RS_HOLD: begin
        if (i_stop) begin
          state_next = RS_IDLE;
          pos_next   = '0;
          reset_next = pos;
          abort_next = 1'b1;
          cnt_next   = '0;
        end else if (i_hold) begin
          state_next = RS_HOLD;
        end else begin
          // Leaving HOLD counts as a normal RUN clock, so a hold of N clocks
          // lengthens the position by exactly N.
          state_next = RS_RUN;
          if (mode_change) begin
            cnt_next = '0;
          end else if (expire) begin
            // The shift drops the last bit off the end, so completion leaves
            // the ring empty without a separate clear.
            pos_next   = {pos[POSITIONS-2:0], 1'b0};
            set_next   = {pos[POSITIONS-2:0], 1'b0};
            reset_next = pos;
            cnt_next   = '0;
            if (pos[POSITIONS-1]) begin
              state_next = RS_IDLE;
              done_next  = 1'b1;
            end
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = RS_IDLE;
        pos_next   = '0;
        cnt_next   = '0;
      end
    endcase

    busy_next = (state_next != RS_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= RS_IDLE;
      pos         <= '0;
      cnt         <= '0;
      set_pulse   <= '0;
      reset_pulse <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      abort       <= 1'b0;
    end else begin
      state       <= state_next;
      pos         <= pos_next;
      cnt         <= cnt_next;
      set_pulse   <= set_next;
      reset_pulse <= reset_next;
      busy        <= busy_next;
      done        <= done_next;
      abort       <= abort_next;
    end
  end

  assign o_pos         = pos;
  assign o_set_pulse   = set_pulse;
  assign o_reset_pulse = reset_pulse;
  assign o_busy        = busy;
  assign o_done        = done;
  assign o_abort       = abort;

endmodule

// File: tb/tb_ring_sequencer.sv
module tb_ring_sequencer;

  localparam int MP = 4;
  localparam int MD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          start = 1'b0, stop = 1'b0, hold = 1'b0;
  logic [MP-1:0] pos, setp, rstp;
  logic          busy, done, abort;

  logic          b_start = 1'b0, b_stop = 1'b0, b_hold = 1'b0;
  logic [1:0]    b_pos, b_set, b_rst;
  logic          b_busy, b_done, b_abort;

`ifdef RING_SINGLE_STEP_EN
  logic step_mode = 1'b0, step = 1'b0;
  logic b_step_mode = 1'b0, b_step = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ring_sequencer #(.POSITIONS(MP), .DWELL(MD)) u_dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_stop        (stop),
    .i_hold        (hold),
`ifdef RING_SINGLE_STEP_EN
    .i_step_mode   (step_mode),
    .i_step        (step),
`endif
    .o_pos         (pos),
    .o_set_pulse   (setp),
    .o_reset_pulse (rstp),
    .o_busy        (busy),
    .o_done        (done),
    .o_abort       (abort)
  );

  ring_sequencer #(.POSITIONS(2), .DWELL(1)) u_dut2 (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_start       (b_start),
    .i_stop        (b_stop),
    .i_hold        (b_hold),
`ifdef RING_SINGLE_STEP_EN
    .i_step_mode   (b_step_mode),
    .i_step        (b_step),
`endif
    .o_pos         (b_pos),
    .o_set_pulse   (b_set),
    .o_reset_pulse (b_rst),
    .o_busy        (b_busy),
    .o_done        (b_done),
    .o_abort       (b_abort)
  );

  // Reference model: position index plus clocks elapsed in that position.
  bit            m_active = 0;
  int            m_idx = 0, m_cnt = 0;
  bit            m_prev_start = 0, m_edge = 0, m_adv = 0;
  logic [MP-1:0] e_pos = '0, e_set = '0, e_rst = '0;
  logic          e_busy = 0, e_done = 0, e_abort = 0;
`ifdef RING_SINGLE_STEP_EN
  bit            m_prev_step = 0, m_step_edge = 0, m_prev_mode = 0;
`endif

  function automatic logic [MP-1:0] onehot(input int k);
    logic [MP-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_idx = 0; m_cnt = 0; m_prev_start = 0; m_edge = 0;
      e_pos = '0; e_set = '0; e_rst = '0; e_busy = 0; e_done = 0; e_abort = 0;
`ifdef RING_SINGLE_STEP_EN
      m_prev_step = 0; m_step_edge = 0; m_prev_mode = 0;
`endif
    end else begin
      e_set = '0; e_rst = '0; e_done = 0; e_abort = 0; m_adv = 0;
      if (!m_active) begin
        if (m_edge && !stop) begin
          m_active = 1; m_idx = 0; m_cnt = 0; e_set = onehot(0);
        end
      end else if (stop) begin
        e_rst = onehot(m_idx); e_abort = 1; m_active = 0;
      end else if (!hold) begin
`ifdef RING_SINGLE_STEP_EN
        if (step_mode != m_prev_mode) m_cnt = 0;
        else if (step_mode) m_adv = m_step_edge;
        else begin m_cnt++; m_adv = (m_cnt == MD); end
`else
        m_cnt++;
        m_adv = (m_cnt == MD);
`endif
        if (m_adv) begin
          e_rst = onehot(m_idx); m_cnt = 0; m_idx++;
          if (m_idx == MP) begin m_active = 0; e_done = 1; end
          else e_set = onehot(m_idx);
        end
      end
      e_pos  = m_active ? onehot(m_idx) : '0;
      e_busy = m_active;
      m_edge = start && !m_prev_start;
      m_prev_start = start;
`ifdef RING_SINGLE_STEP_EN
      m_step_edge = step && !m_prev_step;
      m_prev_step = step;
      m_prev_mode = step_mode;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({pos, setp, rstp, busy, done, abort} !== '0) begin
      errors++; $display("FAIL reset_hold got %b want 0", {pos, setp, rstp, busy, done, abort});
    end
    checks++;
    if ({b_pos, b_set, b_rst, b_busy, b_done, b_abort} !== '0) begin
      errors++; $display("FAIL reset_hold2 got %b want 0", {b_pos, b_set, b_rst, b_busy, b_done, b_abort});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({pos, setp, rstp, busy, done, abort} !== '0) begin
      errors++; $display("FAIL reset_release got %b want 0", {pos, setp, rstp, busy, done, abort});
    end
  endtask

  task automatic test_revolution();
    int busy_cnt, done_at;
    logic [MP-1:0] ps [0:16];
    busy_cnt = 0; done_at = -1;
    start = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      ps[n] = pos;
      if (busy) busy_cnt++;
      if (done) done_at = n;
      checks++;
      if ({pos, setp, rstp, busy, done, abort} !== {e_pos, e_set, e_rst, e_busy, e_done, e_abort}) begin
        errors++; $display("FAIL rev_model n=%0d got %b want %b", n, {pos, setp, rstp, busy, done, abort}, {e_pos, e_set, e_rst, e_busy, e_done, e_abort});
      end
    end
    start = 1'b0;
    checks++;
    if (done_at != 14) begin errors++; $display("FAIL rev_done_at got %0d want 14", done_at); end
    checks++;
    if (busy_cnt != 12) begin errors++; $display("FAIL rev_busy_cnt got %0d want 12", busy_cnt); end
    checks++;
    if ({ps[2], ps[4], ps[5], ps[8], ps[11], ps[13], ps[14]} !== {4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0000}) begin
      errors++; $display("FAIL rev_pos_seq got %b want 0001000100100100100010000000", {ps[2], ps[4], ps[5], ps[8], ps[11], ps[13], ps[14]});
    end
    tick();
  endtask

  task automatic test_hold();
    int busy_cnt, done_at, hold_pulses;
    logic [MP-1:0] p12, p13;
    busy_cnt = 0; done_at = -1; hold_pulses = 0; p12 = '0; p13 = '0;
    start = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) done_at = n;
      if (n >= 7 && n <= 11 && ((setp | rstp) != '0 || pos != 4'b0010)) hold_pulses++;
      if (n == 12) p12 = pos;
      if (n == 13) p13 = pos;
      checks++;
      if ({pos, setp, rstp, busy, done, abort} !== {e_pos, e_set, e_rst, e_busy, e_done, e_abort}) begin
        errors++; $display("FAIL hold_model n=%0d got %b want %b", n, {pos, setp, rstp, busy, done, abort}, {e_pos, e_set, e_rst, e_busy, e_done, e_abort});
      end
      if (n == 2) start = 1'b0;
      if (n == 6) hold = 1'b1;
      if (n == 11) hold = 1'b0;
    end
    checks++;
    if (done_at != 19) begin errors++; $display("FAIL hold_done_at got %0d want 19", done_at); end
    checks++;
    if (busy_cnt != 17) begin errors++; $display("FAIL hold_busy_cnt got %0d want 17", busy_cnt); end
    checks++;
    if (hold_pulses != 0) begin errors++; $display("FAIL hold_frozen got %0d bad clks want 0", hold_pulses); end
    checks++;
    if ({p12, p13} !== {4'b0010, 4'b0100}) begin errors++; $display("FAIL hold_resume got %b want 00100100", {p12, p13}); end
  endtask

  task automatic test_stop();
    int done_cnt, busy_cnt;
    logic [MP-1:0] r9, p9;
    logic a9;
    done_cnt = 0; busy_cnt = 0; r9 = '0; p9 = '1; a9 = 1'b0;
    start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done) done_cnt++;
      if (n == 9) begin r9 = rstp; p9 = pos; a9 = abort; stop = 1'b0; end
      checks++;
      if ({pos, setp, rstp, busy, done, abort} !== {e_pos, e_set, e_rst, e_busy, e_done, e_abort}) begin
        errors++; $display("FAIL stop_model n=%0d got %b want %b", n, {pos, setp, rstp, busy, done, abort}, {e_pos, e_set, e_rst, e_busy, e_done, e_abort});
      end
      if (n == 2) start = 1'b0;
      if (n == 8) stop = 1'b1;
    end
    checks++;
    if ({r9, p9, a9} !== {4'b0100, 4'b0000, 1'b1}) begin
      errors++; $display("FAIL stop_pulse got rst=%b pos=%b abort=%b want 0100 0000 1", r9, p9, a9);
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL stop_no_done got %0d want 0", done_cnt); end
    // Start edge arriving while i_stop is high in IDLE is ignored.
    stop = 1'b1; start = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (busy) busy_cnt++;
      if (n == 4) stop = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (busy_cnt != 0) begin errors++; $display("FAIL stop_idle_start got busy=%0d want 0", busy_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    int busy_cnt, done_cnt;
    busy_cnt = 0; done_cnt = 0;
    start = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      checks++;
      if ({pos, setp, rstp, busy, done, abort} !== {e_pos, e_set, e_rst, e_busy, e_done, e_abort}) begin
        errors++; $display("FAIL b2b_model n=%0d got %b want %b", n, {pos, setp, rstp, busy, done, abort}, {e_pos, e_set, e_rst, e_busy, e_done, e_abort});
      end
      if (n == 5) start = 1'b0;
      if (n == 7) start = 1'b1;
    end
    checks++;
    if ({busy_cnt, done_cnt} != {32'd12, 32'd1}) begin
      errors++; $display("FAIL b2b_busy_edge got busy=%0d done=%0d want 12 1", busy_cnt, done_cnt);
    end
    // Edge landing on the completion clock is dropped.
    start = 1'b0; tick(); tick();
    busy_cnt = 0; done_cnt = 0;
    start = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (n == 3) start = 1'b0;
      if (n == 12) start = 1'b1;
    end
    checks++;
    if ({busy_cnt, done_cnt} != {32'd12, 32'd1}) begin
      errors++; $display("FAIL b2b_done_edge got busy=%0d done=%0d want 12 1", busy_cnt, done_cnt);
    end
    // A fresh edge is honoured.
    start = 1'b0; tick();
    start = 1'b1; tick(); tick();
    checks++;
    if ({busy, pos, setp} !== {1'b1, 4'b0001, 4'b0001}) begin
      errors++; $display("FAIL b2b_restart got %b want 100010001", {busy, pos, setp});
    end
    start = 1'b0;
    for (int n = 0; n < 14; n++) tick();
  endtask

  task automatic test_dwell_one();
    logic [6:0] r [1:5];
    b_start = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      r[n] = {b_pos, b_set, b_rst, b_done};
      if (n == 1) b_start = 1'b0;
    end
    checks++;
    if (r[2] !== 7'b01_01_00_0) begin errors++; $display("FAIL dw1_clk1 got %b want 0101000", r[2]); end
    checks++;
    if (r[3] !== 7'b10_10_01_0) begin errors++; $display("FAIL dw1_clk2 got %b want 1010010", r[3]); end
    checks++;
    if (r[4] !== 7'b00_00_10_1) begin errors++; $display("FAIL dw1_clk3 got %b want 0000101", r[4]); end
    checks++;
    if ({r[5], b_busy} !== 8'b0) begin errors++; $display("FAIL dw1_after got %b want 0", {r[5], b_busy}); end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (n == 2) start = 1'b0;
    end
    checks++;
    if (pos !== 4'b1000) begin errors++; $display("FAIL areset_pre got %b want 1000", pos); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pos, setp, rstp, busy, done, abort} !== '0) begin
      errors++; $display("FAIL areset_now got %b want 0", {pos, setp, rstp, busy, done, abort});
    end
    #2 rst = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      tick();
      checks++;
      if ({pos, setp, rstp, busy, done, abort} !== '0) begin
        errors++; $display("FAIL areset_after n=%0d got %b want 0", n, {pos, setp, rstp, busy, done, abort});
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      tick();
      checks++;
      if ({pos, setp, rstp, busy, done, abort} !== {e_pos, e_set, e_rst, e_busy, e_done, e_abort}) begin
        errors++; $display("FAIL rand_model n=%0d got %b want %b", n, {pos, setp, rstp, busy, done, abort}, {e_pos, e_set, e_rst, e_busy, e_done, e_abort});
      end
      checks++;
      if ((setp & rstp) !== '0) begin errors++; $display("FAIL rand_overlap n=%0d got %b want 0", n, setp & rstp); end
      if ($urandom_range(0, 5) == 0) start = ~start;
      stop = ($urandom_range(0, 24) == 0);
      hold = ($urandom_range(0, 5) == 0);
    end
    start = 1'b0; stop = 1'b1; hold = 1'b0;
    tick(); tick();
    stop = 1'b0;
    tick();
  endtask

`ifdef RING_SINGLE_STEP_EN
  task automatic test_step_mode();
    int done_cnt;
    logic [MP-1:0] p8;
    done_cnt = 0; p8 = '0;
    step_mode = 1'b1; tick(); tick();
    start = 1'b1;
    for (int n = 1; n <= 36; n++) begin
      tick();
      if (done) done_cnt++;
      if (n == 8) p8 = pos;
      checks++;
      if ({pos, setp, rstp, busy, done, abort} !== {e_pos, e_set, e_rst, e_busy, e_done, e_abort}) begin
        errors++; $display("FAIL step_model n=%0d got %b want %b", n, {pos, setp, rstp, busy, done, abort}, {e_pos, e_set, e_rst, e_busy, e_done, e_abort});
      end
      if (n == 2) start = 1'b0;
      step = (n == 10 || n == 16 || n == 22 || n == 28);
    end
    checks++;
    if ({p8, done_cnt[1:0], busy} !== {4'b0001, 2'd1, 1'b0}) begin
      errors++; $display("FAIL step_rev got pos8=%b done=%0d busy=%b want 0001 1 0", p8, done_cnt, busy);
    end
    step_mode = 1'b0; tick(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_revolution();
    test_hold();
    test_stop();
    test_back_to_back();
    test_dwell_one();
    test_random();
`ifdef RING_SINGLE_STEP_EN
    test_step_mode();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
